sort_net_pipe: RTL
==================

Name: sort_net_pipe

Overview:
- Pipelined, parametrised sorting network that orders NUM elements by key field per cycle.
- Successor to the fixed 4-input combinational sorter used by the Huffman frequency-sort path.
- Adds configurable width, power-of-two element count, ascending/descending mode per beat, and valid/ready flow control with full-pipeline stall.
- Sits between the symbol-frequency counter and the Huffman tree builder.

Parameters:
- DSIZE, 18, width of one element in bits.
- OFFSET, 8, the compare key is bits [DSIZE-1:OFFSET]. Bits [OFFSET-1:0] are payload (symbol) and are never compared.
- LOG_NUM, 3, NUM = 2**LOG_NUM elements per beat. Legal range is 1 to 5.
- STAGES, derived, equals LOG_NUM*(LOG_NUM+1)/2 bitonic compare stages. It is a localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block accepts a beat this cycle.
- in_desc  input  1  0 = ascending (smallest key at element 0), 1 = descending. Sampled with the beat.
- in_data  input  NUM*DSIZE  element i is in_data[i*DSIZE +: DSIZE].
- out_valid  output  1  output beat valid.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  NUM*DSIZE  sorted elements, element 0 first in the selected order.
- out_desc  output  1  mode the beat was sorted with.
- busy  output  1  any pipeline stage holds a valid beat.

Behaviour:
- Network:
  - Bitonic sorter with STAGES compare-exchange layers and one register bank after each layer.
  - Each register bank holds NUM*DSIZE data, 1 desc bit and 1 valid bit.
- Compare-exchange element:
  - Inputs lo and hi; direction dir is per element, fixed by network position, XORed with the stage's desc bit.
  - Swap only when key(lo) > key(hi) for that element's ascending direction, or key(lo) < key(hi) for its descending direction.
  - Equal keys never swap.
  - Keys are compared unsigned, width DSIZE-OFFSET.
  - Full words move together, so payload follows its key.
- Flow control:
  - Global enable en = ~out_valid | out_ready.
  - in_ready = en, combinational. No skid buffer.
  - When en = 1, every stage register loads from the previous stage. Stage 0 loads in_data, in_desc and (in_valid & in_ready).
  - When en = 0, all stage registers hold their contents, including bubbles.
- Outputs:
  - out_valid, out_data and out_desc come from the last stage register.
  - out_valid stays high and out_data stays stable until out_ready = 1.
- Latency:
  - An accepted beat appears at the outputs exactly STAGES cycles after acceptance, provided en was high throughout.
  - Each cycle with en = 0 adds one cycle.
- Throughput: one beat per cycle while out_ready = 1.
- Bubbles: a cycle with in_valid = 0 and en = 1 inserts an invalid slot. Invalid slots are never presented (out_valid = 0).
- busy = OR of all stage valid bits.
- Reset:
  - Asynchronous.
  - All valid bits and desc bits clear to 0; all data registers clear to 0.
  - After reset: out_valid = 0, out_data = 0, out_desc = 0, busy = 0, in_ready = 1.
  - Reset asserted mid-stream discards every in-flight beat. No partial beat is ever emitted after release.
- Mode change: desc travels with its beat. Back-to-back beats with different modes are each sorted correctly; no pipeline flush is required.
- Boundary cases:
  - LOG_NUM = 1 gives STAGES = 1, a single compare-exchange.
  - OFFSET = 0 makes the whole word the key. OFFSET >= DSIZE is illegal and flagged by an elaboration-time check.
  - All-equal keys pass through unpermuted.

Test Plan:
- Reset, then one beat, defaults (LOG_NUM=3, DSIZE=18, OFFSET=8):
  - Keys 7,3,9,1,9,0,5,2 with symbols 0..7, in_desc=0, out_ready=1.
  - Required after 6 cycles: keys 0,1,2,3,5,7,9,9; symbols follow their keys (key 0→sym 5, key 1→sym 3).
  - out_valid high for exactly one cycle.
- Same beat with in_desc=1: keys 9,9,7,5,3,2,1,0 and out_desc=1.
- Stream of 20 random beats with alternating desc and out_ready held at 1:
  - One output per cycle after 6-cycle fill.
  - Each output is sorted in its own mode and is a permutation of its input words.
- Backpressure:
  - out_ready=0 for 4 cycles while 10 beats stream.
  - in_ready drops the same cycle out_valid=1 and out_ready=0.
  - out_data holds stable; no beat is lost or duplicated; order is preserved.
- Payload isolation: all keys equal to 0x3FF with distinct payloads → output equals input unchanged.
- Reset mid-operation: assert rst_n=0 with 3 beats in flight → out_valid and busy go to 0 immediately and stay 0 after release until a new beat has travelled 6 cycles.

Source files
------------

// File: rtl/sort_net_pipe.sv
// Pipelined bitonic sorting network: NUM elements per beat ordered by key field,
// one register bank per compare-exchange layer, global stall from the output side.
module sort_net_pipe #(
    parameter  int DSIZE   = 18,
    parameter  int OFFSET  = 8,
    parameter  int LOG_NUM = 3,
    localparam int NUM     = 2 ** LOG_NUM,
    localparam int STAGES  = LOG_NUM * (LOG_NUM + 1) / 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_desc,
    input  logic [NUM*DSIZE-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [NUM*DSIZE-1:0]   out_data,
    output logic                   out_desc,
    output logic                   busy
);

    localparam int KW = DSIZE - OFFSET;

    typedef logic [DSIZE-1:0] elem_t;

    if (OFFSET >= DSIZE) begin : g_bad_offset
        $error("sort_net_pipe: OFFSET must be smaller than DSIZE");
    end
    if (LOG_NUM < 1 || LOG_NUM > 5) begin : g_bad_log_num
        $error("sort_net_pipe: LOG_NUM must be in 1..5");
    end

    // Handshake: a beat moves on clk rising when valid & ready are both high.
    // ready depends only on the output register state and out_ready, so the
    // whole pipeline advances or holds as one unit (no skid storage).
    logic  w_en;
    elem_t w_in      [STAGES][NUM];
    elem_t w_cx      [STAGES][NUM];
    logic  w_desc_in [STAGES];

    elem_t               r_data [STAGES][NUM];
    logic [STAGES-1:0]   r_valid;
    logic [STAGES-1:0]   r_desc;

    assign w_en     = ~r_valid[STAGES-1] | out_ready;
    assign in_ready = w_en;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage_in
        if (s == 0) begin : g_first
            assign w_desc_in[s] = in_desc;
            for (genvar i = 0; i < NUM; i++) begin : g_elem
                assign w_in[s][i] = in_data[i*DSIZE +: DSIZE];
            end
        end else begin : g_next
            assign w_desc_in[s] = r_desc[s-1];
            for (genvar i = 0; i < NUM; i++) begin : g_elem
                assign w_in[s][i] = r_data[s-1][i];
            end
        end
    end

    // Phase p merges bitonic runs of length 2**p; sub-layer q compares
    // elements 2**q apart. Block direction flips on bit p of the element index.
    for (genvar p = 1; p <= LOG_NUM; p++) begin : g_phase
        for (genvar q = p - 1; q >= 0; q--) begin : g_sub
            localparam int S = p * (p - 1) / 2 + (p - 1 - q);
            localparam int K = 1 << p;
            localparam int J = 1 << q;
            for (genvar i = 0; i < NUM; i++) begin : g_elem
                if ((i & J) == 0) begin : g_cx
                    localparam int L       = i + J;
                    localparam bit BLK_DSC = ((i & K) != 0);

                    logic          w_dir_desc;
                    logic          w_swap;
                    logic [KW-1:0] w_klo;
                    logic [KW-1:0] w_khi;

                    assign w_klo      = w_in[S][i][DSIZE-1:OFFSET];
                    assign w_khi      = w_in[S][L][DSIZE-1:OFFSET];
                    assign w_dir_desc = BLK_DSC ^ w_desc_in[S];
                    // Strict compares: equal keys stay where they are.
                    assign w_swap     = w_dir_desc ? (w_klo < w_khi) : (w_klo > w_khi);
                    assign w_cx[S][i] = w_swap ? w_in[S][L] : w_in[S][i];
                    assign w_cx[S][L] = w_swap ? w_in[S][i] : w_in[S][L];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_desc  <= '0;
            for (int s = 0; s < STAGES; s++) begin
                for (int i = 0; i < NUM; i++) begin
                    r_data[s][i] <= '0;
                end
            end
        end else if (w_en) begin
            r_valid[0] <= in_valid & w_en;
            r_desc[0]  <= in_desc;
            for (int s = 1; s < STAGES; s++) begin
                r_valid[s] <= r_valid[s-1];
                r_desc[s]  <= r_desc[s-1];
            end
            for (int s = 0; s < STAGES; s++) begin
                for (int i = 0; i < NUM; i++) begin
                    r_data[s][i] <= w_cx[s][i];
                end
            end
        end
    end

    for (genvar i = 0; i < NUM; i++) begin : g_out
        assign out_data[i*DSIZE +: DSIZE] = r_data[STAGES-1][i];
    end

    assign out_valid = r_valid[STAGES-1];
    assign out_desc  = r_desc[STAGES-1];
    assign busy      = |r_valid;

endmodule
